// File: rtl/heat_grid_vga_render_pkg.sv
// heat_vga_pkg: shared timing defaults, grid geometry, colour type and the
// temperature-to-colour map used by the heat grid VGA renderer.
package heat_vga_pkg;

  // 640x480@60 raster defaults
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Grid placement defaults (cell edge must be a power of two)
  localparam int DEF_CELL_PX  = 64;
  localparam int DEF_GRID_X0  = 160;
  localparam int DEF_GRID_Y0  = 80;

  // Solver geometry
  localparam int GRID_DIM = 5;
  localparam int TEMP_W   = 4;
  localparam int ADDR_W   = 5;

  // 2 bits per channel, matching the TinyVGA PMOD
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb2_t;

  localparam rgb2_t RGB_BLACK = '{r: 2'b00, g: 2'b00, b: 2'b00};

  // Cold is blue, hot is red; green lights up only in the two middle bands
  // so the transition passes through cyan/yellow-ish tones.
  function automatic rgb2_t heat_colour(input logic [TEMP_W-1:0] t);
    rgb2_t c;
    logic  mid;
    mid = t[3] ^ t[2];
    c.r = t[3:2];
    c.g = {mid, t[1] & mid};
    c.b = ~t[3:2];
    return c;
  endfunction

endpackage

// File: rtl/heat_grid_vga_render_vga_timing.sv
// vga_timing: free-running pixel/line counters with raw sync, active-area
// decode and a registered once-per-frame tick at the start of vertical blank.
module vga_timing
  import heat_vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HCNT_W  = $clog2(H_TOTAL),
  localparam int VCNT_W  = $clog2(V_TOTAL)
)(
  input  logic              clk,
  input  logic              rst,
  output logic [HCNT_W-1:0] hcnt,
  output logic [VCNT_W-1:0] vcnt,
  output logic              active,
  output logic              hsync_raw,
  output logic              vsync_raw,
  output logic              frame_tick
);

  localparam logic [HCNT_W-1:0] H_LAST_C   = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_ACT_C    = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0] HS_START_C = HCNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCNT_W-1:0] HS_END_C   = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCNT_W-1:0] V_LAST_C   = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_ACT_C    = VCNT_W'(V_ACTIVE);
  localparam logic [VCNT_W-1:0] VS_START_C = VCNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCNT_W-1:0] VS_END_C   = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [HCNT_W-1:0] hcnt_r;
  logic [VCNT_W-1:0] vcnt_r;
  logic [HCNT_W-1:0] hcnt_nxt_s;
  logic [VCNT_W-1:0] vcnt_nxt_s;
  logic              frame_tick_r;

  // Next raster position: pixel wraps at end of line, line wraps at end of frame.
  always_comb begin
    hcnt_nxt_s = hcnt_r;
    vcnt_nxt_s = vcnt_r;
    if (hcnt_r == H_LAST_C) begin
      hcnt_nxt_s = '0;
      if (vcnt_r == V_LAST_C) begin
        vcnt_nxt_s = '0;
      end else begin
        vcnt_nxt_s = vcnt_r + VCNT_W'(1'b1);
      end
    end else begin
      hcnt_nxt_s = hcnt_r + HCNT_W'(1'b1);
      vcnt_nxt_s = vcnt_r;
    end
  end

  // Counter state plus the frame tick, registered from the next position so it
  // is high exactly while the counters read (0, V_ACTIVE).
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_r       <= '0;
      vcnt_r       <= '0;
      frame_tick_r <= 1'b0;
    end else begin
      hcnt_r       <= hcnt_nxt_s;
      vcnt_r       <= vcnt_nxt_s;
      frame_tick_r <= (hcnt_nxt_s == '0) && (vcnt_nxt_s == V_ACT_C);
    end
  end

  assign hcnt       = hcnt_r;
  assign vcnt       = vcnt_r;
  assign active     = (hcnt_r < H_ACT_C) && (vcnt_r < V_ACT_C);
  assign hsync_raw  = !((hcnt_r >= HS_START_C) && (hcnt_r < HS_END_C));
  assign vsync_raw  = !((vcnt_r >= VS_START_C) && (vcnt_r < VS_END_C));
  assign frame_tick = frame_tick_r;

endmodule

// File: rtl/heat_grid_vga_render.sv
// heat_grid_vga_render: scans the VGA raster, fetches one solver cell per
// pixel and paints it as a 2-bit-per-channel heat colour. RGB and syncs both
// reach the pins two clocks after the counter value they belong to.
// cell_data must reflect cell_addr by the clock edge after cell_addr updates.
// Optional build macro GRID_LINES_EN: paints white cell borders over the map.
module heat_grid_vga_render
  import heat_vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CELL_PX  = DEF_CELL_PX,
  parameter int GRID_X0  = DEF_GRID_X0,
  parameter int GRID_Y0  = DEF_GRID_Y0
)(
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] cell_addr,
  input  logic [TEMP_W-1:0] cell_data,
  output logic [1:0]        vga_r,
  output logic [1:0]        vga_g,
  output logic [1:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              frame_tick
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCNT_W     = $clog2(H_TOTAL);
  localparam int VCNT_W     = $clog2(V_TOTAL);
  localparam int CELL_SHIFT = $clog2(CELL_PX);
  localparam int GRID_PX    = GRID_DIM * CELL_PX;
  localparam int IDX_W      = $clog2(GRID_DIM);

  localparam logic [HCNT_W-1:0] GX0_C = HCNT_W'(GRID_X0);
  localparam logic [HCNT_W-1:0] GX1_C = HCNT_W'(GRID_X0 + GRID_PX);
  localparam logic [VCNT_W-1:0] GY0_C = VCNT_W'(GRID_Y0);
  localparam logic [VCNT_W-1:0] GY1_C = VCNT_W'(GRID_Y0 + GRID_PX);

  // Stage 0: raster position
  logic [HCNT_W-1:0] hcnt_s;
  logic [VCNT_W-1:0] vcnt_s;
  logic              active_s;
  logic              hsync_raw_s;
  logic              vsync_raw_s;
  logic              frame_tick_s;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .hcnt       (hcnt_s),
    .vcnt       (vcnt_s),
    .active     (active_s),
    .hsync_raw  (hsync_raw_s),
    .vsync_raw  (vsync_raw_s),
    .frame_tick (frame_tick_s)
  );

  // Stage 0: grid decode. Offsets wrap outside the grid but are only used
  // when in_grid_s qualifies them.
  logic [HCNT_W-1:0] x_off_s;
  logic [VCNT_W-1:0] y_off_s;
  logic [IDX_W-1:0]  col_s;
  logic [IDX_W-1:0]  row_s;
  logic [ADDR_W-1:0] cell_idx_s;
  logic              in_grid_s;

  assign x_off_s    = hcnt_s - GX0_C;
  assign y_off_s    = vcnt_s - GY0_C;
  assign col_s      = IDX_W'(x_off_s >> CELL_SHIFT);
  assign row_s      = IDX_W'(y_off_s >> CELL_SHIFT);
  assign cell_idx_s = ADDR_W'(row_s) * ADDR_W'(GRID_DIM) + ADDR_W'(col_s);
  assign in_grid_s  = active_s
                   && (hcnt_s >= GX0_C) && (hcnt_s < GX1_C)
                   && (vcnt_s >= GY0_C) && (vcnt_s < GY1_C);

`ifdef GRID_LINES_EN
  localparam logic [HCNT_W-1:0] GXL_C = HCNT_W'(GRID_X0 + GRID_PX - 1);
  localparam logic [VCNT_W-1:0] GYL_C = VCNT_W'(GRID_Y0 + GRID_PX - 1);
  localparam rgb2_t RGB_WHITE_C = '{r: 2'b11, g: 2'b11, b: 2'b11};

  logic grid_line_s;
  logic grid_line_d1_r;

  // A pixel is on a border when it starts a cell row/column or closes the grid.
  assign grid_line_s = in_grid_s
                    && ((x_off_s[CELL_SHIFT-1:0] == '0)
                     || (y_off_s[CELL_SHIFT-1:0] == '0)
                     || (hcnt_s == GXL_C)
                     || (vcnt_s == GYL_C));
`endif

  // Stage 1 state
  logic [ADDR_W-1:0] cell_addr_r;
  logic              active_d1_r;
  logic              in_grid_d1_r;
  logic              hsync_d1_r;
  logic              vsync_d1_r;

  // Stage 1: present the cell address (held outside the grid) and delay the
  // qualifiers and syncs so they line up with the returning cell_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cell_addr_r    <= '0;
      active_d1_r    <= 1'b0;
      in_grid_d1_r   <= 1'b0;
      hsync_d1_r     <= 1'b1;
      vsync_d1_r     <= 1'b1;
`ifdef GRID_LINES_EN
      grid_line_d1_r <= 1'b0;
`endif
    end else begin
      if (in_grid_s) begin
        cell_addr_r <= cell_idx_s;
      end else begin
        cell_addr_r <= cell_addr_r;
      end
      active_d1_r    <= active_s;
      in_grid_d1_r   <= in_grid_s;
      hsync_d1_r     <= hsync_raw_s;
      vsync_d1_r     <= vsync_raw_s;
`ifdef GRID_LINES_EN
      grid_line_d1_r <= grid_line_s;
`endif
    end
  end

  // Stage 2 state
  rgb2_t pix_s;
  rgb2_t rgb_r;
  logic  hsync_r;
  logic  vsync_r;

  // Colour for the pixel whose cell_data is on the bus this cycle; black
  // outside the grid and throughout blanking.
  always_comb begin
    pix_s = RGB_BLACK;
    if (active_d1_r && in_grid_d1_r) begin
`ifdef GRID_LINES_EN
      if (grid_line_d1_r) begin
        pix_s = RGB_WHITE_C;
      end else begin
        pix_s = heat_colour(cell_data);
      end
`else
      pix_s = heat_colour(cell_data);
`endif
    end else begin
      pix_s = RGB_BLACK;
    end
  end

  // Stage 2: register colour and syncs so every pin changes on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r   <= RGB_BLACK;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else begin
      rgb_r   <= pix_s;
      hsync_r <= hsync_d1_r;
      vsync_r <= vsync_d1_r;
    end
  end

  assign cell_addr  = cell_addr_r;
  assign vga_r      = rgb_r.r;
  assign vga_g      = rgb_r.g;
  assign vga_b      = rgb_r.b;
  assign vga_hsync  = hsync_r;
  assign vga_vsync  = vsync_r;
  assign frame_tick = frame_tick_s;

endmodule

// File: doc/heat_grid_vga_render.md
Name: heat_grid_vga_render

Overview:
Downstream display stage of the 5x5 heat solver. Scans a 640x480@60 VGA raster and reads one solver cell per pixel through a synchronous read port. Maps each 4-bit temperature to a 2-bit-per-channel heat colour for the TinyVGA PMOD. Emits a once-per-frame tick so the solver can run its iterations during vertical blanking.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse lines
V_BP, 33, vertical back porch
CELL_PX, 64, cell edge length in pixels; must be a power of 2
GRID_X0, 160, first pixel column of the grid
GRID_Y0, 80, first line of the grid

Ports:
clk  in  1  pixel clock, 25 MHz nominal
rst  in  1  reset, synchronous, active-high
cell_addr  out  5  solver cell index row*5+col, 0..24, registered
cell_data  in  4  temperature of cell_addr; valid 1 cycle after cell_addr changes
vga_r  out  2  red
vga_g  out  2  green
vga_b  out  2  blue
vga_hsync  out  1  horizontal sync, active-low
vga_vsync  out  1  vertical sync, active-low
frame_tick  out  1  1-cycle pulse at start of vertical blank

Behaviour:
- Single clock domain. Reset: synchronous, active-high, all state cleared on the clk edge where rst=1.
- Reset values: hcnt=0, vcnt=0, cell_addr=0, vga_r/g/b=0, vga_hsync=1, vga_vsync=1, frame_tick=0. Pipeline valid bits cleared.
- Counters: hcnt 0..799 wraps to 0; on that wrap vcnt increments 0..524, then wraps to 0. Totals derive from the parameters: 800 clocks per line, 525 lines, 420000 clocks per frame.
- Stage 0 (counters): active = hcnt<H_ACTIVE && vcnt<V_ACTIVE. in_grid = active && GRID_X0<=hcnt<GRID_X0+5*CELL_PX && GRID_Y0<=vcnt<GRID_Y0+5*CELL_PX.
  - col=(hcnt-GRID_X0)>>log2(CELL_PX); row likewise on vcnt.
  - Raw hsync low when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC. Raw vsync is decoded the same way on vcnt.
- Stage 1: register cell_addr=row*5+col when in_grid; otherwise hold the previous value. Delay active, in_grid and syncs one stage.
- Stage 2: register colours from cell_data and register the syncs. Total latency from counter value to pins is 2 cycles for RGB and sync alike.
- Colour map for temperature t:
  - r=t[3:2]
  - b=~t[3:2]
  - g={t[3]^t[2], t[1]&(t[3]^t[2])}
  - Check values: t=0 gives r00 g00 b11; t=10 gives r10 g11 b01; t=12 gives r11 g00 b00; t=15 gives r11 g00 b00.
- Outside the grid while active: RGB=0. During blanking: RGB forced 0.
- frame_tick=1 for exactly the one cycle when the registered counters read hcnt=0, vcnt=V_ACTIVE. It is not pipeline-delayed.
- cell_data is sampled only in the cycle after cell_addr is presented. Solver writes mid-frame are allowed; a torn frame is acceptable.
- Reset mid-frame: the next edge gives reset values, and the raster restarts at (0,0) the cycle after rst deasserts. No partial sync pulse may persist.

Optional Feature:
GRID_LINES_EN
- Defined: pixels inside the grid whose x or y offset within the cell is 0, plus the closing right and bottom edges, render RGB=11/11/11. This overrides the heat colour.
- Undefined: no overlay. Output is the pure heat map, and the gridline decode logic is absent.

Decomposition:
- Package heat_vga_pkg:
  - VGA timing defaults
  - GRID_DIM=5, TEMP_W=4, ADDR_W=5
  - rgb2_t struct {r,g,b}
  - pure function heat_colour(t)
- One sub-module: vga_timing. Owns hcnt/vcnt, raw syncs, active and frame_tick; parameterised by the timing values.
- heat_grid_vga_render holds the grid decode, the read pipeline and the colour stage.

Test Plan:
- Reset, then free-run one frame. Required: hsync low for exactly 96 clocks per line, first low output 2 cycles after hcnt=656; line period 800; vsync low for 2 lines; frame_tick period 420000.
- Model cell 12=10 (1-cycle read latency), drive pixel (320,240). Required: cell_addr=12; RGB=10/11/01 two cycles later.
- Cells 0 and 24: drive cell 0=0 and cell 24=15. Required: pixel (160,80) gives 00/00/11; pixel (479,399) gives 11/00/00.
- Grid boundary: pixels (159,240) and (480,240) give RGB 0; pixel (700,240) (blanking) gives RGB 0 with cell_data=15.
- Assert rst for 1 cycle at vcnt=300. Required: next cycle outputs are reset values; the following frame_tick arrives exactly 480*800 cycles after release.
- GRID_LINES_EN: pixel (224,80) gives RGB 11/11/11; pixel (225,81) gives the heat colour. Without the macro, pixel (224,80) gives the heat colour.
